// File: rtl/vram_scanout_arbiter_if.sv
// CPU request/ack bus into the VRAM scanout arbiter.
// master: CPU drives req/we/addr/wdata; slave: arbiter returns ack/rdata.
interface vram_scanout_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vram_scanout_arbiter.sv
// Shares the 256x8 CHIP-8 display RAM between CPU and VGA scanout.
// Ports: clk, reset (sync, high); counter_x/y, counter_x_10 from sync gen;
//   cpu (slave bus: req/we/addr/wdata -> ack/rdata);
//   mem_addr/mem_we/mem_wdata/mem_rdata to the RAM; pixel_on to video.
module vram_scanout_arbiter #(
  parameter int H_DISPLAY    = 640,
  parameter int ACTIVE_LINES = 320,
  parameter int V_TOTAL      = 525,
  parameter int SCALE        = 10,
  parameter int ROWS         = 32,
  parameter int FETCH_X      = 656
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   counter_x,
  input  logic [9:0]                   counter_y,
  input  logic [5:0]                   counter_x_10,
  vram_scanout_arbiter_if.slave        cpu,
  output logic [7:0]                   mem_addr,
  output logic                         mem_we,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata,
  output logic                         pixel_on
);

  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SCALE);

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    CPU_ACK,
    FETCH,
    FETCH_LAST
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      k;
  logic [2:0]      k_nx;
  logic            fetch_pending;
  logic            fetch_go;
  logic [RW-1:0]   next_row;
  logic [SW-1:0]   sub;
  logic [7:0]      lb [8];
  logic            lb_we;
  logic [2:0]      lb_idx;

  logic trig_x;
  logic last_line;
  logic img_line;

  assign trig_x    = counter_x == 10'(FETCH_X);
  assign last_line = counter_y == 10'(V_TOTAL - 1);
  assign img_line  = counter_y < 10'(ACTIVE_LINES - 1);

  always_comb begin
    state_nx      = state;
    k_nx          = k;
    fetch_go      = 1'b0;
    mem_addr      = 8'h00;
    mem_we        = 1'b0;
    mem_wdata     = 8'h00;
    cpu.cpu_ack   = 1'b0;
    cpu.cpu_rdata = 8'h00;
    lb_we         = 1'b0;
    lb_idx        = 3'd0;
    unique case (state)
      IDLE: begin
        if (fetch_pending) begin
          state_nx = FETCH;
          k_nx     = 3'd0;
          fetch_go = 1'b1;
        end else if (cpu.cpu_req) begin
          state_nx = CPU_ACC;
        end
      end
      CPU_ACC: begin
        mem_addr  = cpu.cpu_addr;
        mem_we    = cpu.cpu_we;
        mem_wdata = cpu.cpu_wdata;
        state_nx  = CPU_ACK;
      end
      CPU_ACK: begin
        cpu.cpu_ack   = 1'b1;
        cpu.cpu_rdata = mem_rdata;
        state_nx      = IDLE;
      end
      FETCH: begin
        mem_addr = 8'({next_row, k});
        // RAM data lags the address by one cycle
        lb_we    = k != 3'd0;
        lb_idx   = k - 3'd1;
        k_nx     = k + 3'd1;
        if (k == 3'd7) state_nx = FETCH_LAST;
      end
      FETCH_LAST: begin
        lb_we    = 1'b1;
        lb_idx   = 3'd7;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      k             <= 3'd0;
      fetch_pending <= 1'b0;
      next_row      <= '0;
      sub           <= '0;
      pixel_on      <= 1'b0;
      for (int i = 0; i < 8; i++) lb[i] <= 8'h00;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      if (lb_we) lb[lb_idx] <= mem_rdata;
      // column c lives in byte c/8, bit 7-(c%8)
      pixel_on <= (counter_x < 10'(H_DISPLAY))
               && (counter_y < 10'(ACTIVE_LINES))
               && lb[counter_x_10[5:3]][~counter_x_10[2:0]];
      if (fetch_go) fetch_pending <= 1'b0;
      // a new trigger wins over the clear
      if (trig_x) begin
        if (last_line) begin
          next_row      <= '0;
          sub           <= '0;
          fetch_pending <= 1'b1;
        end else if (img_line) begin
          if (sub == SW'(SCALE - 1)) begin
            sub           <= '0;
            next_row      <= next_row + 1'b1;
            fetch_pending <= 1'b1;
          end else begin
            sub <= sub + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Scoreboard bench for vram_scanout_arbiter.
// Counter generator skips most of each line to keep frames short.
module tb_vram_scanout_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ram_clr;
  logic [9:0] counter_x;
  logic [9:0] counter_y;
  logic [5:0] counter_x_10;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       pixel_on;

  vram_scanout_arbiter_if cpu ();

  vram_scanout_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .counter_x    (counter_x),
    .counter_y    (counter_y),
    .counter_x_10 (counter_x_10),
    .cpu          (cpu),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .pixel_on     (pixel_on)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    logic       pix;
    logic       chk_bus;
    logic [7:0] addr;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  typedef struct packed {
    logic       rd;
    logic [7:0] data;
  } cexp_t;

  exp_t  pq[$];
  cexp_t cq[$];

  int chk  = 0;
  int pass = 0;

  logic [7:0] shadow [256];
  logic [7:0] m_lb [8];
  int         m_sub;
  int         m_row;
  bit         f_act;
  int         f_row;

  task automatic step(input int x, input int y);
    exp_t e;
    @(negedge clk);
    counter_x    = 10'(x);
    counter_y    = 10'(y);
    counter_x_10 = 6'(x / 10);
    #2;
    e.x       = 10'(x);
    e.y       = 10'(y);
    e.pix     = 1'b0;
    e.chk_bus = 1'b0;
    e.addr    = 8'h00;
    if (!reset && x < 640 && y < 320)
      e.pix = m_lb[(x / 10) / 8][7 - ((x / 10) % 8)];
    if (reset) begin
      m_sub = 0;
      m_row = 0;
      f_act = 0;
      for (int b = 0; b < 8; b++) m_lb[b] = 8'h00;
    end else begin
      if (f_act && x >= 657 && x <= 664) begin
        e.chk_bus = 1'b1;
        e.addr    = 8'(f_row * 8 + x - 657);
      end
      if (x == 656) begin
        if (y == 524) begin
          m_row = 0;
          m_sub = 0;
          f_act = 1;
          f_row = 0;
        end else if (y < 319) begin
          if (m_sub == 9) begin
            m_sub = 0;
            m_row++;
            f_act = 1;
            f_row = m_row;
          end else begin
            m_sub++;
          end
        end
      end
      if (x == 670 && f_act) begin
        for (int b = 0; b < 8; b++) m_lb[b] = shadow[f_row * 8 + b];
        f_act = 0;
      end
    end
    pq.push_back(e);
  endtask

  initial begin
    int y;
    counter_x    = 10'd0;
    counter_y    = 10'd520;
    counter_x_10 = 6'd0;
    m_sub = 0;
    m_row = 0;
    f_act = 0;
    f_row = 0;
    for (int b = 0; b < 8; b++) m_lb[b] = 8'h00;
    y = 520;
    forever begin
      if (y == 0 || y == 10 || y == 320) begin
        for (int x = 0; x < 800; x++) step(x, y);
      end else begin
        for (int x = 0; x < 10; x++) step(x, y);
        for (int x = 650; x <= 670; x++) step(x, y);
      end
      y = (y == 524) ? 0 : y + 1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (pq.size() > 0) begin
        e = pq.pop_front();
        chk++;
        if (pixel_on === e.pix) pass++;
        else $display("FAIL pixel x=%0d y=%0d got %b want %b",
                      e.x, e.y, pixel_on, e.pix);
        if (e.chk_bus) begin
          chk++;
          if (mem_addr === e.addr && mem_we === 1'b0) pass++;
          else $display("FAIL fetch_bus y=%0d got addr=%h we=%b want addr=%h we=0",
                        e.y, mem_addr, mem_we, e.addr);
        end
      end
    end
  end

  initial begin
    cexp_t c;
    bit ack_prev = 0;
    bit we_prev  = 0;
    forever begin
      @(negedge clk);
      if (we_prev) begin
        chk++;
        if (cpu.cpu_ack === 1'b1) pass++;
        else $display("FAIL we_then_ack got ack=%b want 1", cpu.cpu_ack);
      end
      if (cpu.cpu_ack === 1'b1) begin
        chk++;
        if (!ack_prev) pass++;
        else $display("FAIL ack_gap got consecutive acks want single pulse");
        chk++;
        if (cq.size() != 0) begin
          pass++;
          c = cq.pop_front();
          if (c.rd) begin
            chk++;
            if (cpu.cpu_rdata === c.data) pass++;
            else $display("FAIL rdata got %h want %h", cpu.cpu_rdata, c.data);
          end
        end else begin
          $display("FAIL spurious_ack got ack=1 want no ack");
        end
      end
      ack_prev = cpu.cpu_ack === 1'b1;
      we_prev  = mem_we === 1'b1;
    end
  end

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(counter_x == 10'(x) && counter_y == 10'(y)) && n < 60000);
    if (n >= 60000) begin
      chk++;
      $display("FAIL wait_xy timeout want x=%0d y=%0d", x, y);
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [7:0] a,
                          input logic [7:0] d, input int lo, input int hi);
    int    lat;
    cexp_t c;
    @(negedge clk);
    #1;
    cpu.cpu_req   = 1'b1;
    cpu.cpu_we    = we;
    cpu.cpu_addr  = a;
    cpu.cpu_wdata = d;
    c.rd   = !we;
    c.data = shadow[a];
    cq.push_back(c);
    if (we) shadow[a] = d;
    lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (cpu.cpu_ack !== 1'b1 && lat < 40);
    cpu.cpu_req = 1'b0;
    chk++;
    if (lat >= lo && lat <= hi) pass++;
    else $display("FAIL latency addr=%h got %0d want %0d..%0d", a, lat, lo, hi);
  endtask

  initial begin
    logic [7:0] row0 [8];
    reset         = 1'b1;
    ram_clr       = 1'b1;
    cpu.cpu_req   = 1'b0;
    cpu.cpu_we    = 1'b0;
    cpu.cpu_addr  = 8'h00;
    cpu.cpu_wdata = 8'h00;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    row0[0] = 8'h80;
    for (int i = 1; i < 7; i++) row0[i] = 8'h00;
    row0[7] = 8'h01;
    repeat (3) @(negedge clk);
    #1;
    reset   = 1'b0;
    ram_clr = 1'b0;

    for (int i = 0; i < 8; i++) cpu_xfer(1'b1, 8'(i), row0[i], 2, 2);

    wait_xy(0, 2);
    cpu_xfer(1'b1, 8'h08, 8'hFF, 2, 2);
    cpu_xfer(1'b0, 8'h08, 8'h00, 2, 2);

    wait_xy(653, 19);
    cpu_xfer(1'b0, 8'h08, 8'h00, 2, 2);
    wait_xy(656, 29);
    cpu_xfer(1'b0, 8'h00, 8'h00, 12, 12);

    wait_xy(0, 41);
    for (int i = 0; i < 6; i++) cpu_xfer(1'b0, 8'(i), 8'h00, 2, 2);
    wait_xy(650, 49);
    for (int i = 0; i < 6; i++) cpu_xfer(1'b0, 8'(i), 8'h00, 2, 13);

    wait_xy(0, 2);
    cpu_xfer(1'b1, 8'h08, 8'h00, 2, 2);
    wait_xy(660, 59);
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;

    wait_xy(9, 1);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
